sprite_blitter: RTL and testbench

- Parametrised rectangular image copier: walks an SPR_W x SPR_H image held in an external synchronous ROM and streams each pixel to the VGA adapter at a runtime-selected screen origin.
- Replaces the per-screen fixed-size, fixed-origin draw blocks.
- Adds a start/done handshake, a parametrised ROM latency and screen-edge clipping.
- Sits between the game FSM (start/done) and the VGA adapter's x/y/colour/plot inputs; ROM is instantiated by the parent.

---
 rtl/vga_pkg.sv | 19 +
 rtl/sprite_blitter_if.sv | 30 +++
 rtl/blit_delay_line.sv | 34 +++
 rtl/sprite_blitter.sv | 184 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and blitter state encoding.
package vga_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 9;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;

  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Blitter bus: game-FSM handshake, external ROM port and VGA adapter outputs.
interface sprite_blitter_if #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W
) ();
  import vga_pkg::*;

  logic                start;
  logic [X_W-1:0]      origin_x;
  logic [Y_W-1:0]      origin_y;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

  modport master (
    output start, origin_x, origin_y, rom_data,
    input  busy, done, rom_addr, x, y, colour, plot
  );

  modport slave (
    input  start, origin_x, origin_y, rom_data,
    output busy, done, rom_addr, x, y, colour, plot
  );

endinterface

// File: rtl/blit_delay_line.sv
// DEPTH-stage register chain aligning pixel coordinates with synchronous ROM latency.
module blit_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Streams an SPR_W x SPR_H ROM image to the VGA adapter at a runtime origin, with screen clipping.
// Optional colour-key transparency: define SPRITE_BLITTER_TRANSPARENCY_EN.
module sprite_blitter #(
  parameter int unsigned SPR_W    = 80,
  parameter int unsigned SPR_H    = 40,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned COLOUR_W = vga_pkg::COLOUR_W,
  parameter int unsigned SCREEN_W = vga_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = vga_pkg::SCREEN_H,
  parameter int unsigned ROM_LAT  = 1,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input  logic           clk,
  input  logic           resetn,
  sprite_blitter_if.slave bus
);
  import vga_pkg::*;

  localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned DL_W  = 1 + COL_W + ROW_W;
  localparam int unsigned DRN_W = $clog2(ROM_LAT + 2);

  blit_state_t         state_q, state_d;
  logic [X_W-1:0]      ox_q, ox_d;
  logic [Y_W-1:0]      oy_q, oy_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;

  logic                push_valid_c;
  logic [DL_W-1:0]     dl_out_c;
  logic                dl_valid_c;
  logic [COL_W-1:0]    dl_col_c;
  logic [ROW_W-1:0]    dl_row_c;
  logic [X_W:0]        sum_x_c;
  logic [Y_W:0]        sum_y_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  // Sequencer: raster-walks the image, then flushes the ROM/delay pipeline.
  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    col_d        = col_q;
    row_d        = row_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    push_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ox_d    = bus.origin_x;
          oy_d    = bus.origin_y;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        push_valid_c = 1'b1;
        addr_d       = addr_q + ADDR_W'(1);
        if (col_q == COL_W'(SPR_W - 1)) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_W'(SPR_H - 1)) begin
            // Hold counters on the last pixel so addr never passes the image end.
            col_d   = col_q;
            row_d   = row_q;
            addr_d  = addr_q;
            drain_d = '0;
            state_d = DRAIN;
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DRN_W'(ROM_LAT)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FETCH) || (state_d == DRAIN) || (state_d == DONE);
    done_d = (state_q == DONE);
  end

  blit_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (DL_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (resetn),
    .din   ({push_valid_c, col_q, row_q}),
    .dout  (dl_out_c)
  );

  assign dl_valid_c = dl_out_c[DL_W-1];
  assign dl_col_c   = dl_out_c[ROW_W +: COL_W];
  assign dl_row_c   = dl_out_c[0 +: ROW_W];

  // Output stage: pair delayed coordinate with ROM data, clip to the visible screen.
  always_comb begin
    sum_x_c  = (X_W+1)'(ox_q) + (X_W+1)'(dl_col_c);
    sum_y_c  = (Y_W+1)'(oy_q) + (Y_W+1)'(dl_row_c);
    plot_d   = dl_valid_c
             && (sum_x_c < (X_W+1)'(SCREEN_W))
             && (sum_y_c < (Y_W+1)'(SCREEN_H));
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    if (bus.rom_data == KEY_COLOUR) begin
      plot_d = 1'b0;
    end
`endif
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (plot_d) begin
      x_d      = sum_x_c[X_W-1:0];
      y_d      = sum_y_c[Y_W-1:0];
      colour_d = bus.rom_data;
    end
  end

`ifndef SPRITE_BLITTER_TRANSPARENCY_EN
  logic unused_key_c;
  assign unused_key_c = ^KEY_COLOUR;
`endif

  assign bus.rom_addr = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench: 4x2 blitter (ROM_LAT=1) and 80x40 blitter (ROM_LAT=3) with ROM[i]=i.
module tb_sprite_blitter;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sprite_blitter_if #(.ADDR_W(4))  a_if ();
  sprite_blitter_if #(.ADDR_W(12)) b_if ();

  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ADDR_W(4), .ROM_LAT(1)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (a_if.slave)
  );

  sprite_blitter #(.SPR_W(80), .SPR_H(40), .ADDR_W(12), .ROM_LAT(3)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b_if.slave)
  );

  // Synchronous ROMs holding ROM[i] = i (truncated to the colour width).
  logic [3:0]  a_pipe;
  logic [11:0] b_pipe [3];
  always @(posedge clk) begin
    a_pipe    <= a_if.rom_addr;
    b_pipe[0] <= b_if.rom_addr;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_if.rom_data = 9'(a_pipe);
  assign b_if.rom_data = b_pipe[2][8:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One 4x2 blit on dut_a, every cycle checked from the start-accept edge to the done pulse.
  task automatic blit_a(input int ox, input int oy, output int nplots);
    int p;
    int sx;
    int sy;
    logic exp_plot;
    nplots = 0;
    @(negedge clk);
    a_if.start    = 1'b1;
    a_if.origin_x = 8'(ox);
    a_if.origin_y = 7'(oy);
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c == 0) a_if.start = 1'b0;
      if (c < 8) chk("a_rom_addr", 32'(a_if.rom_addr), 32'(c));
      chk("a_busy", 32'(a_if.busy), 32'(c <= 10));
      chk("a_done", 32'(a_if.done), 32'(c == 11));
      p = c - 2;
      if (p >= 0 && p < 8) begin
        sx = ox + (p % 4);
        sy = oy + (p / 4);
        exp_plot = (sx < 160) && (sy < 120);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
        if (p == 0) exp_plot = 1'b0;
`endif
        chk("a_plot", 32'(a_if.plot), 32'(exp_plot));
        if (exp_plot) begin
          nplots++;
          chk("a_x", 32'(a_if.x), 32'(sx));
          chk("a_y", 32'(a_if.y), 32'(sy));
          chk("a_colour", 32'(a_if.colour), 32'(p));
        end
      end else begin
        chk("a_plot_off", 32'(a_if.plot), 32'd0);
      end
    end
  endtask

  initial begin
    int n;
    int p;
    int sx;
    int sy;
    logic exp_plot;

    resetn        = 1'b0;
    a_if.start    = 1'b0;
    a_if.origin_x = '0;
    a_if.origin_y = '0;
    b_if.start    = 1'b0;
    b_if.origin_x = '0;
    b_if.origin_y = '0;

    #3;
    chk("rst_plot", 32'(a_if.plot), 32'd0);
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    chk("rst_done", 32'(a_if.done), 32'd0);
    chk("rst_addr", 32'(a_if.rom_addr), 32'd0);
    chk("rst_x", 32'(a_if.x), 32'd0);
    chk("rst_colour", 32'(a_if.colour), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(a_if.busy), 32'd0);

    // Basic 4x2 blit at (10,20).
    blit_a(10, 20, n);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    chk("basic_count", 32'(n), 32'd7);
`else
    chk("basic_count", 32'(n), 32'd8);
`endif

    // Clipping at the bottom-right corner.
    blit_a(158, 119, n);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    chk("clip_count", 32'(n), 32'd1);
`else
    chk("clip_count", 32'(n), 32'd2);
`endif

    // Re-trigger: start held high, origin changed mid-blit, then a FETCH-time start pulse.
    @(negedge clk);
    a_if.start    = 1'b1;
    a_if.origin_x = 8'd30;
    a_if.origin_y = 7'd40;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("rt_x1", 32'(a_if.x), 32'd31);
        chk("rt_y1", 32'(a_if.y), 32'd40);
        chk("rt_c1", 32'(a_if.colour), 32'd1);
      end
      if (c == 4) begin
        a_if.origin_x = 8'd1;
        a_if.origin_y = 7'd2;
      end
      if (c == 9) begin
        chk("rt_x7", 32'(a_if.x), 32'd33);
        chk("rt_y7", 32'(a_if.y), 32'd41);
      end
      if (c == 10) chk("rt_busy10", 32'(a_if.busy), 32'd1);
      if (c == 11) begin
        chk("rt_done11", 32'(a_if.done), 32'd1);
        chk("rt_busy11", 32'(a_if.busy), 32'd0);
      end
      if (c == 12) begin
        chk("rt_busy12", 32'(a_if.busy), 32'd1);
        chk("rt_done12", 32'(a_if.done), 32'd0);
        a_if.start = 1'b0;
      end
      if (c == 15) begin
        chk("rt2_x1", 32'(a_if.x), 32'd2);
        chk("rt2_y1", 32'(a_if.y), 32'd2);
        chk("rt2_plot", 32'(a_if.plot), 32'd1);
        a_if.start    = 1'b1;
        a_if.origin_x = 8'd50;
      end
      if (c == 16) a_if.start = 1'b0;
      if (c == 18) chk("rt2_x4", 32'(a_if.x), 32'd1);
      if (c == 22) chk("rt2_done22", 32'(a_if.done), 32'd0);
      if (c == 23) chk("rt2_done23", 32'(a_if.done), 32'd1);
      if (c == 24) begin
        chk("rt2_busy24", 32'(a_if.busy), 32'd0);
        chk("rt2_done24", 32'(a_if.done), 32'd0);
      end
    end

    // Asynchronous reset while pixel 5 is on the outputs.
    @(negedge clk);
    a_if.start    = 1'b1;
    a_if.origin_x = 8'd10;
    a_if.origin_y = 7'd20;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) a_if.start = 1'b0;
    end
    chk("mr_pre_plot", 32'(a_if.plot), 32'd1);
    chk("mr_pre_x", 32'(a_if.x), 32'd11);
    #2 resetn = 1'b0;
    #1;
    chk("mr_plot", 32'(a_if.plot), 32'd0);
    chk("mr_busy", 32'(a_if.busy), 32'd0);
    chk("mr_done", 32'(a_if.done), 32'd0);
    chk("mr_addr", 32'(a_if.rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("mr_no_done", 32'(a_if.done), 32'd0);
      chk("mr_idle", 32'(a_if.busy), 32'd0);
    end
    blit_a(10, 20, n);
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    chk("mr_count", 32'(n), 32'd7);
`else
    chk("mr_count", 32'(n), 32'd8);
`endif

    // Full 80x40 image with ROM_LAT=3 at (39,39).
    @(negedge clk);
    b_if.start    = 1'b1;
    b_if.origin_x = 8'd39;
    b_if.origin_y = 7'd39;
    n = 0;
    for (int c = 0; c <= 3205; c++) begin
      @(negedge clk);
      if (c == 0) b_if.start = 1'b0;
      if (c < 3200) chk("b_rom_addr", 32'(b_if.rom_addr), 32'(c));
      chk("b_busy", 32'(b_if.busy), 32'(c <= 3204));
      chk("b_done", 32'(b_if.done), 32'(c == 3205));
      p = c - 4;
      if (p >= 0 && p < 3200) begin
        sx = 39 + (p % 80);
        sy = 39 + (p / 80);
        exp_plot = 1'b1;
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
        if ((p % 512) == 0) exp_plot = 1'b0;
`endif
        chk("b_plot", 32'(b_if.plot), 32'(exp_plot));
        if (exp_plot) begin
          n++;
          chk("b_x", 32'(b_if.x), 32'(sx));
          chk("b_y", 32'(b_if.y), 32'(sy));
          chk("b_colour", 32'(b_if.colour), 32'(p % 512));
        end
        if (p == 3199) begin
          chk("b_last_x", 32'(b_if.x), 32'd118);
          chk("b_last_y", 32'(b_if.y), 32'd78);
        end
      end else begin
        chk("b_plot_off", 32'(b_if.plot), 32'd0);
      end
    end
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
    chk("b_count", 32'(n), 32'd3193);
`else
    chk("b_count", 32'(n), 32'd3200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
